// File: rtl/fb_pkg.sv
// Shared framebuffer definitions for the write-side fill engine and the
// scan-out controller: screen geometry, pixel/address types, the fill
// command record and the fill engine state encoding.
package fb_pkg;

    localparam int unsigned H_RES  = 640;  // horizontal resolution in pixels
    localparam int unsigned V_RES  = 480;  // vertical resolution in lines
    localparam int unsigned ADDR_W = 19;   // framebuffer address width
    localparam int unsigned PIX_W  = 24;   // RGB888, R in [23:16]

    typedef logic [23:0] pixel_t;
    typedef logic [18:0] fb_addr_t;

    typedef struct packed {
        logic [9:0] x0;
        logic [9:0] y0;
        logic [9:0] w;
        logic [9:0] h;
        pixel_t     color;
        logic       sync;
    } fill_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYNC,
        FILL,
        DONE
    } fill_state_t;

    // A command covers no on-screen pixel: empty size or origin off-screen.
    function automatic logic cmd_is_null(input fill_cmd_t c);
        return (c.w == 10'd0) || (c.h == 10'd0) ||
               (c.x0 >= 10'(H_RES)) || (c.y0 >= 10'(V_RES));
    endfunction

endpackage

// File: rtl/fb_rect_addr_gen.sv
// Rectangle address generator: clips a fill command to the screen and walks
// its pixels in row-major order, producing y*H_RES + x without a multiplier.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              latch x0/y0/w/h and point at the first pixel
//   advance           current pixel was written; step to the next one
//   x0, y0, w, h      command geometry (only sampled on load)
//   addr              address of the current pixel (registered)
//   last              current pixel is the bottom-right one of the clipped box
module fb_rect_addr_gen
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [9:0]        x0,
    input  logic [9:0]        y0,
    input  logic [9:0]        w,
    input  logic [9:0]        h,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [9:0]        x_q, x_d, y_q, y_d, x0_q, x0_d;
    logic [10:0]       x_end_q, x_end_d, y_end_q, y_end_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;

    logic [10:0]       x_sum, y_sum, x_next, y_next;
    logic [ADDR_W-1:0] y0_ext, y0_base;
    logic              row_end;

    // 11-bit sums cannot wrap, so the clip is a plain compare.
    assign x_sum   = {1'b0, x0} + {1'b0, w};
    assign y_sum   = {1'b0, y0} + {1'b0, h};
    // y0 * 640 = y0 * 512 + y0 * 128.
    assign y0_ext  = ADDR_W'(y0);
    assign y0_base = (y0_ext << 9) + (y0_ext << 7);

    assign x_next  = {1'b0, x_q} + 11'd1;
    assign y_next  = {1'b0, y_q} + 11'd1;
    assign row_end = (x_next == x_end_q);
    assign last    = row_end && (y_next == y_end_q);
    assign addr    = addr_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        x_d        = x_q;
        y_d        = y_q;
        x0_d       = x0_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;

        if (load) begin
            x_d        = x0;
            y_d        = y0;
            x0_d       = x0;
            x_end_d    = (x_sum > 11'(H_RES)) ? 11'(H_RES) : x_sum;
            y_end_d    = (y_sum > 11'(V_RES)) ? 11'(V_RES) : y_sum;
            row_base_d = y0_base;
            addr_d     = y0_base + ADDR_W'(x0);
        end else if (advance) begin
            if (row_end) begin
                // Wrap to the next line; computed from row_base so the
                // first pixel of the new row is ready with no bubble.
                x_d        = x0_q;
                y_d        = y_q + 10'd1;
                row_base_d = row_base_q + ADDR_W'(H_RES);
                addr_d     = row_base_q + ADDR_W'(H_RES) + ADDR_W'(x0_q);
            end else begin
                x_d    = x_q + 10'd1;
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these are a handful of control registers, not a storage
        // array, so all of them are reset; addr must read 0 after reset.
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            x0_q       <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            x0_q       <= x0_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: rtl/fb_rect_fill.sv
// Framebuffer rectangle fill engine. Accepts a fill command, clips it to the
// screen and writes one pixel per granted cycle through the framebuffer write
// port, optionally waiting for frame_start before the first write.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid / cmd_ready       command handshake
//   cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, cmd_sync   command fields
//   cmd_abort                   abandon the command in WAIT_SYNC or FILL
//   frame_start                 frame pulse from the VGA timing generator
//   fb_wr_en/addr/data, fb_wr_gnt   framebuffer write port and grant
//   busy                        command in progress
//   done                        one-cycle pulse on normal completion
module fb_rect_fill
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x0,
    input  logic [9:0]        cmd_y0,
    input  logic [9:0]        cmd_w,
    input  logic [9:0]        cmd_h,
    input  logic [PIX_W-1:0]  cmd_color,
    input  logic              cmd_sync,
    input  logic              cmd_abort,
    input  logic              frame_start,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [PIX_W-1:0]  fb_wr_data,
    input  logic              fb_wr_gnt,
    output logic              busy,
    output logic              done
);

    fill_state_t state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        fb_wr_en_q, fb_wr_en_d;
    pixel_t      fb_wr_data_q, fb_wr_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    fill_cmd_t   cmd_in;
    logic        gen_load, gen_advance, gen_last;
    logic        wr_fire;

    assign cmd_in = '{x0: cmd_x0, y0: cmd_y0, w: cmd_w, h: cmd_h,
                      color: cmd_color, sync: cmd_sync};
    assign wr_fire = fb_wr_en_q && fb_wr_gnt;

    fb_rect_addr_gen u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (gen_load),
        .advance (gen_advance),
        .x0      (cmd_in.x0),
        .y0      (cmd_in.y0),
        .w       (cmd_in.w),
        .h       (cmd_in.h),
        .addr    (fb_wr_addr),
        .last    (gen_last)
    );

    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        fb_wr_en_d   = fb_wr_en_q;
        fb_wr_data_d = fb_wr_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        gen_load     = 1'b0;
        gen_advance  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    gen_load     = 1'b1;
                    fb_wr_data_d = cmd_in.color;
                    cmd_ready_d  = 1'b0;
                    busy_d       = 1'b1;
                    if (cmd_is_null(cmd_in)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (cmd_in.sync) begin
                        state_d = WAIT_SYNC;
                    end else begin
                        // Raising the request on the entry edge gives the
                        // first write in the cycle right after accept.
                        state_d    = FILL;
                        fb_wr_en_d = 1'b1;
                    end
                end
            end
            WAIT_SYNC: begin
                if (cmd_abort) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end else if (frame_start) begin
                    state_d    = FILL;
                    fb_wr_en_d = 1'b1;
                end
            end
            FILL: begin
                // A granted write completes even on the abort cycle.
                gen_advance = wr_fire;
                if (cmd_abort) begin
                    state_d     = IDLE;
                    fb_wr_en_d  = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end else if (wr_fire && gen_last) begin
                    state_d    = DONE;
                    fb_wr_en_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
            DONE: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                fb_wr_en_d  = 1'b0;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            fb_wr_en_q   <= 1'b0;
            fb_wr_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            fb_wr_en_q   <= fb_wr_en_d;
            fb_wr_data_q <= fb_wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign fb_wr_en   = fb_wr_en_q;
    assign fb_wr_data = fb_wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/fb_rect_fill.md
Name: fb_rect_fill

Overview:
- Framebuffer write-side fill engine, upstream of the VGA scan-out controller.
- Accepts rectangle-fill commands (origin, size, RGB888 colour), clips them to 640x480 and writes one pixel per granted cycle into the framebuffer write port.
- Row-major address = y*640 + x, the same layout the scan-out reads.
- Used for screen clear, background fill and simple UI boxes. An optional mode defers the fill start to the frame_start pulse to avoid tearing.

Parameters:
- H_RES, 640, horizontal resolution in pixels.
- V_RES, 480, vertical resolution in lines.
- ADDR_W, 19, framebuffer address width.
- PIX_W, 24, pixel width (RGB888, R in [23:16]).

Ports:
- clk  in  1  pixel/system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_x0  in  10  left column.
- cmd_y0  in  10  top line.
- cmd_w  in  10  width in pixels.
- cmd_h  in  10  height in lines.
- cmd_color  in  PIX_W  fill colour.
- cmd_sync  in  1  1 = wait for frame_start before the first write.
- cmd_abort  in  1  abandon the current command.
- frame_start  in  1  single-cycle pulse from the VGA timing generator.
- fb_wr_en  out  1  write request.
- fb_wr_addr  out  ADDR_W  write address.
- fb_wr_data  out  PIX_W  write data.
- fb_wr_gnt  in  1  arbiter grant; a write completes when fb_wr_en and fb_wr_gnt are both 1.
- busy  out  1  a command is in progress.
- done  out  1  single-cycle pulse when a command completes.

Behaviour:
- Reset values:
  - cmd_ready=1; fb_wr_en=0; fb_wr_addr=0; fb_wr_data=0; busy=0; done=0.
  - FSM in IDLE.
  - Reset is asynchronous and effective mid-command; the partial fill is left in memory.
- FSM states: IDLE, WAIT_SYNC, FILL, DONE.
- IDLE:
  - cmd_ready=1.
  - A command is accepted when cmd_valid && cmd_ready; all cmd_* fields are latched.
  - Next state: WAIT_SYNC if cmd_sync=1, else FILL.
  - A null command goes directly to DONE with zero writes. A command is null when cmd_w==0, cmd_h==0, cmd_x0>=H_RES or cmd_y0>=V_RES.
- Clipping, computed at accept:
  - x_end = min(x0+w, H_RES) and y_end = min(y0+h, V_RES).
  - The sums are 11-bit, so there is no wrap.
- WAIT_SYNC: go to FILL on the cycle after frame_start=1. frame_start pulses while not in WAIT_SYNC are ignored.
- FILL:
  - fb_wr_en, fb_wr_addr and fb_wr_data are registered outputs.
  - The first fb_wr_en=1 appears the cycle after entering FILL, with addr = y0*640 + x0.
  - The address is generated incrementally, with no multiplier:
    - row_base starts at y0*640, computed once as (y0<<9)+(y0<<7);
    - each completed write gives addr+1;
    - at end of row, row_base += 640 and addr = row_base + x0.
  - When fb_wr_gnt=0, fb_wr_en, fb_wr_addr and fb_wr_data hold stable until granted.
  - Throughput is 1 pixel/cycle with continuous grant, with no bubble at row wrap.
- End of fill:
  - The write at (x_end-1, y_end-1) is the last write.
  - fb_wr_en drops the cycle after it is granted, and the FSM goes to DONE in that same cycle.
- DONE:
  - done=1 for exactly one cycle; cmd_ready=0.
  - Next state is IDLE.
- busy=1 in WAIT_SYNC, FILL and DONE.
- cmd_abort in WAIT_SYNC or FILL:
  - The next cycle is in IDLE with fb_wr_en=0 and no done pulse.
  - A write presented on the abort cycle with fb_wr_gnt=1 counts as completed.
  - cmd_abort is ignored in IDLE and DONE.
- If cmd_abort and the last-write grant occur in the same cycle, abort wins: no done pulse.
- Latency: for a 1x1 command at (0,0) with cmd_sync=0 and gnt tied to 1:
  - accept at cycle T;
  - fb_wr_en at T+1;
  - done at T+2;
  - cmd_ready at T+3.

Decomposition:
- Package fb_pkg holds:
  - the H_RES/V_RES/ADDR_W/PIX_W constants;
  - typedef pixel_t (logic[23:0]);
  - typedef fb_addr_t (logic[18:0]);
  - a struct fill_cmd_t with x0, y0, w, h, color and sync;
  - the FSM state enum.
- The scan-out controller uses the same package.
- A natural sub-module is fb_rect_addr_gen: clipping plus the row/column counters and incremental address, with advance/last handshake.
- The FSM and output registers stay in fb_rect_fill.

Test Plan:
- Full-screen clear: x0=0 y0=0 w=640 h=480, color=0x000000, gnt=1 -> exactly 307200 writes at addresses 0..307199 in order, all data 0, with done after the last.
- Clipped box: x0=630 y0=470 w=20 h=20, color=0xFF0000 -> 100 writes. Rows 470..479 each cover addr base+630..base+639, first addr 301430, last 307199.
- Stall hold: 4x1 at (2,1) with gnt toggling 1,0,0,1,... -> addresses 642..645 each held stable while gnt=0. Exactly 4 completions, no duplicates or skips.
- Sync start: cmd_sync=1 with frame_start pulsing 50 cycles after accept -> no fb_wr_en before the pulse, first write the cycle after the pulse. A frame_start pulse during FILL has no effect.
- Null/abort:
  - w=0 -> zero writes, done 1 cycle after accept.
  - cmd_abort at the 10th write of a 100x1 command -> fb_wr_en=0 the next cycle, no done pulse, cmd_ready=1.
- Reset mid-fill: rst_n=0 during FILL -> all outputs immediately at reset values. A new command after release starts from its own x0,y0.
